// File: rtl/cpu_pkg.sv
// Constants and the ROB entry layout shared by rename, execute and the reorder buffer.
package cpu_pkg;

    localparam int ARCH_W    = 5;
    localparam int PHYS_W    = 6;
    localparam int ROB_DEPTH = 16;
    localparam int ROB_TAG_W = 4;

    typedef struct packed {
        logic              valid;
        logic              done;
        logic              has_rd;
        logic [ARCH_W-1:0] ard;
        logic [PHYS_W-1:0] prd;
        logic [PHYS_W-1:0] old_prd;
    } rob_entry_t;

endpackage

// File: rtl/reorder_buffer.sv
// In-order retirement buffer: circular queue of renamed instructions, completion by tag,
// at most one in-order retirement per cycle releasing the previous phys mapping.
module reorder_buffer
    import cpu_pkg::*;
#(
    parameter int DEPTH = ROB_DEPTH,
    parameter int TAG_W = ROB_TAG_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              disp_valid,
    input  logic              disp_has_rd,
    input  logic [ARCH_W-1:0] disp_ard,
    input  logic [PHYS_W-1:0] disp_prd,
    input  logic [PHYS_W-1:0] disp_old_prd,
    output logic              disp_ready,
    output logic [TAG_W-1:0]  disp_tag,
    input  logic              cmpl_valid,
    input  logic [TAG_W-1:0]  cmpl_tag,
    output logic              ret_valid,
    output logic              ret_has_rd,
    output logic [ARCH_W-1:0] ret_ard,
    output logic [PHYS_W-1:0] ret_prd,
    output logic [PHYS_W-1:0] ret_old_prd,
    output logic              rob_empty
);

    localparam logic [TAG_W:0] DEPTH_C = (TAG_W+1)'(DEPTH);

    rob_entry_t          r_rob [DEPTH];
    logic [TAG_W-1:0]    r_head;
    logic [TAG_W-1:0]    r_tail;
    logic [TAG_W:0]      r_count;
    logic                r_ret_valid;
    logic                r_ret_has_rd;
    logic [ARCH_W-1:0]   r_ret_ard;
    logic [PHYS_W-1:0]   r_ret_prd;
    logic [PHYS_W-1:0]   r_ret_old_prd;

    logic                w_acc_disp;
    logic                w_retire;
    logic                w_cmpl_hit;

    // Dispatch handshake: a transfer happens on a rising edge where disp_valid and
    // disp_ready are both high; disp_ready depends only on registered state, so a
    // retire in the same cycle never opens a slot for that cycle's dispatch.
    assign disp_ready = (r_count < DEPTH_C);
    assign disp_tag   = r_tail;
    assign rob_empty  = (r_count == '0);
    assign w_acc_disp = disp_valid & disp_ready;
    assign w_retire   = r_rob[r_head].valid & r_rob[r_head].done;
    assign w_cmpl_hit = cmpl_valid & r_rob[cmpl_tag].valid & ~r_rob[cmpl_tag].done;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_rob[i] <= '0;
            end
        end else begin
            if (w_acc_disp) begin
                r_rob[r_tail] <= '{valid: 1'b1, done: 1'b0, has_rd: disp_has_rd,
                                   ard: disp_ard, prd: disp_prd, old_prd: disp_old_prd};
                r_tail <= r_tail + 1'b1;
            end
            // A completing tag cannot equal the tail slot being written: that slot is invalid.
            if (w_cmpl_hit) begin
                r_rob[cmpl_tag].done <= 1'b1;
            end
            if (w_retire) begin
                r_rob[r_head].valid <= 1'b0;
                r_head <= r_head + 1'b1;
            end
            case ({w_acc_disp, w_retire})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ret_valid   <= 1'b0;
            r_ret_has_rd  <= 1'b0;
            r_ret_ard     <= '0;
            r_ret_prd     <= '0;
            r_ret_old_prd <= '0;
        end else begin
            r_ret_valid <= w_retire;
            if (w_retire) begin
                r_ret_has_rd  <= r_rob[r_head].has_rd;
                r_ret_ard     <= r_rob[r_head].ard;
                r_ret_prd     <= r_rob[r_head].prd;
                r_ret_old_prd <= r_rob[r_head].old_prd;
            end
        end
    end

    assign ret_valid   = r_ret_valid;
    assign ret_has_rd  = r_ret_has_rd;
    assign ret_ard     = r_ret_ard;
    assign ret_prd     = r_ret_prd;
    assign ret_old_prd = r_ret_old_prd;

endmodule
